gol_frame_engine: RTL and testbench



---
 rtl/gol_pkg.sv | 35 +++
 rtl/gol_cell_rule.sv | 21 ++
 rtl/gol_frame_engine.sv | 181 ++++++++++++++++++
 tb/tb_gol_frame_engine.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gol_pkg.sv
// Shared types and constants for the Game of Life frame engine.
// States, default grid geometry, LFSR definition and pixel colours.
package gol_pkg;

    localparam int GOL_GRID_W     = 80;
    localparam int GOL_GRID_H     = 60;
    localparam int GOL_CELL_SHIFT = 3;

    localparam int LFSR_W = 16;
    // x^16+x^14+x^13+x^11+1 as right-shift taps: bits 0, 2, 3, 5
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;

    localparam logic [3:0] BIRTH_N   = 4'd3;
    localparam logic [3:0] SURVIVE_N = 4'd2;

    localparam logic [7:0] COL_ALIVE = 8'hFF;
    localparam logic [7:0] COL_DEAD  = 8'h00;
    localparam logic [7:0] COL_GRID  = 8'h20;

    typedef enum logic [2:0] {
        ST_SEED,
        ST_IDLE,
        ST_LOAD,
        ST_CELL,
        ST_STORE,
        ST_SWAP
    } state_t;

    function automatic logic [LFSR_W-1:0] lfsr_next(
        input logic [LFSR_W-1:0] s
    );
        return {^(s & LFSR_TAPS), s[LFSR_W-1:1]};
    endfunction

endpackage

// File: rtl/gol_cell_rule.sv
// Combinational Life rule for one cell given its 3x3 neighbourhood.
// i_mid[1] is the centre cell.
module gol_cell_rule
    import gol_pkg::*;
(
    input  logic [2:0] i_top,
    input  logic [2:0] i_mid,
    input  logic [2:0] i_bot,
    output logic       o_next
);

    logic [3:0] w_n;

    always_comb begin
        w_n = 4'(i_top[0]) + 4'(i_top[1]) + 4'(i_top[2])
            + 4'(i_mid[0]) + 4'(i_mid[2])
            + 4'(i_bot[0]) + 4'(i_bot[1]) + 4'(i_bot[2]);
        o_next = (w_n == BIRTH_N) | (i_mid[1] & (w_n == SURVIVE_N));
    end

endmodule

// File: rtl/gol_frame_engine.sv
// Game of Life engine: double-buffered grid, vblank stepping, pixel lookup.
// Define GOL_GRID_LINES_EN to draw gray cell borders on dead pixels.
module gol_frame_engine
    import gol_pkg::*;
#(
    parameter int GRID_W        = GOL_GRID_W,
    parameter int GRID_H        = GOL_GRID_H,
    parameter int CELL_SHIFT    = GOL_CELL_SHIFT,
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        step_en,
    input  logic        wr_en,
    input  logic [5:0]  wr_row,
    input  logic [6:0]  wr_col,
    input  logic        wr_val,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b,
    output logic        busy,
    output logic [15:0] generation
);

    localparam int ROW_W = $clog2(GRID_H);
    localparam int COL_W = $clog2(GRID_W);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(GRID_H - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(GRID_W - 1);

    state_t r_state;
    state_t w_nstate;

    logic [GRID_W-1:0] r_buf [2][GRID_H];
    logic [GRID_W-1:0] r_up;
    logic [GRID_W-1:0] r_mid;
    logic [GRID_W-1:0] r_dn;
    logic [GRID_W-1:0] r_next;
    logic [ROW_W-1:0]  r_row;
    logic [COL_W-1:0]  r_col;
    logic [LFSR_W-1:0] r_lfsr;
    logic              r_front;
    logic [15:0]       r_gen;
    logic [7:0]        r_pix;

    logic              w_trig;
    logic              w_poke;
    logic [ROW_W-1:0]  w_row_up;
    logic [ROW_W-1:0]  w_row_dn;
    logic [COL_W-1:0]  w_col_l;
    logic [COL_W-1:0]  w_col_r;
    logic              w_next;
    logic              w_vis;
    logic [9:0]        w_pr;
    logic [9:0]        w_pc;
    logic              w_cell;
    logic [7:0]        w_colour;

    assign w_trig = (x == 10'd0) && (y == 10'(SCREEN_HEIGHT)) && step_en;
    assign w_poke = (r_state == ST_IDLE) && !w_trig && wr_en
                 && (32'(wr_row) < GRID_H) && (32'(wr_col) < GRID_W);

    assign w_row_up = (r_row == '0) ? ROW_LAST : r_row - ROW_W'(1);
    assign w_row_dn = (r_row == ROW_LAST) ? '0 : r_row + ROW_W'(1);
    assign w_col_l  = (r_col == '0) ? COL_LAST : r_col - COL_W'(1);
    assign w_col_r  = (r_col == COL_LAST) ? '0 : r_col + COL_W'(1);

    gol_cell_rule u_rule (
        .i_top  ({r_up[w_col_l],  r_up[r_col],  r_up[w_col_r]}),
        .i_mid  ({r_mid[w_col_l], r_mid[r_col], r_mid[w_col_r]}),
        .i_bot  ({r_dn[w_col_l],  r_dn[r_col],  r_dn[w_col_r]}),
        .o_next (w_next)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_SEED;
        else     r_state <= w_nstate;
    end

    always_comb begin
        w_nstate = r_state;
        unique case (r_state)
            ST_SEED:  if (r_row == ROW_LAST && r_col == COL_LAST)
                          w_nstate = ST_IDLE;
            ST_IDLE:  if (w_trig) w_nstate = ST_LOAD;
            ST_LOAD:  w_nstate = ST_CELL;
            ST_CELL:  if (r_col == COL_LAST) w_nstate = ST_STORE;
            ST_STORE: w_nstate = (r_row == ROW_LAST) ? ST_SWAP : ST_LOAD;
            ST_SWAP:  w_nstate = ST_IDLE;
            default:  w_nstate = ST_SEED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr  <= LFSR_SEED;
            r_front <= 1'b0;
            r_gen   <= '0;
            r_row   <= '0;
            r_col   <= '0;
        end else begin
            unique case (r_state)
                ST_SEED: begin
                    r_lfsr <= lfsr_next(r_lfsr);
                    if (r_col == COL_LAST) begin
                        r_col <= '0;
                        r_row <= (r_row == ROW_LAST) ? '0 : r_row + ROW_W'(1);
                    end else begin
                        r_col <= r_col + COL_W'(1);
                    end
                end
                ST_IDLE: if (w_trig) r_row <= '0;
                ST_LOAD: begin
                    r_up  <= r_buf[r_front][w_row_up];
                    r_mid <= r_buf[r_front][r_row];
                    r_dn  <= r_buf[r_front][w_row_dn];
                    r_col <= '0;
                end
                ST_CELL: begin
                    r_next[r_col] <= w_next;
                    r_col         <= r_col + COL_W'(1);
                end
                ST_STORE: if (r_row != ROW_LAST) r_row <= r_row + ROW_W'(1);
                ST_SWAP: begin
                    r_front <= ~r_front;
                    r_gen   <= r_gen + 16'd1;
                end
                default: ;
            endcase
        end
    end

    // Grid storage is never reset; SEED rewrites the whole front buffer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == ST_SEED)
                r_buf[1'b0][r_row][r_col] <= r_lfsr[0];
            if (w_poke)
                r_buf[r_front][ROW_W'(wr_row)][COL_W'(wr_col)] <= wr_val;
            if (r_state == ST_STORE)
                r_buf[~r_front][r_row] <= r_next;
        end
    end

    always_comb begin
        w_vis  = (32'(x) < SCREEN_WIDTH) && (32'(y) < SCREEN_HEIGHT);
        w_pr   = y >> CELL_SHIFT;
        w_pc   = x >> CELL_SHIFT;
        w_cell = 1'b0;
        if (w_vis && (32'(w_pr) < GRID_H) && (32'(w_pc) < GRID_W))
            w_cell = r_buf[r_front][ROW_W'(w_pr)][COL_W'(w_pc)];
        w_colour = COL_DEAD;
        if (r_state != ST_SEED && w_vis) begin
            if (w_cell) begin
                w_colour = COL_ALIVE;
            end else begin
`ifdef GOL_GRID_LINES_EN
                if (x[CELL_SHIFT-1:0] == '0 || y[CELL_SHIFT-1:0] == '0)
                    w_colour = COL_GRID;
`else
                w_colour = COL_DEAD;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_pix <= COL_DEAD;
        else     r_pix <= w_colour;
    end

    assign r          = r_pix;
    assign g          = r_pix;
    assign b          = r_pix;
    assign busy       = (r_state != ST_IDLE);
    assign generation = r_gen;

endmodule

// File: tb/tb_gol_frame_engine.sv
// Bench for gol_frame_engine: random pokes and patterns vs a grid model.
// Cells are read back through the pixel port, one pixel per cycle.
module tb_gol_frame_engine;

    localparam int GW = 80;
    localparam int GH = 60;
    localparam int STEP_LEN = GH * (GW + 2) + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        step_en;
    logic        wr_en;
    logic [5:0]  wr_row;
    logic [6:0]  wr_col;
    logic        wr_val;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic        busy;
    logic [15:0] generation;

    int n_tests = 0;
    int n_fail  = 0;
    bit m [GH][GW];
    bit seed_m [GH][GW];
    int exp_gen = 0;

    always #5 clk = ~clk;

    gol_frame_engine #(
        .GRID_W(GW), .GRID_H(GH), .CELL_SHIFT(3),
        .SCREEN_WIDTH(640), .SCREEN_HEIGHT(480), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .rst(rst), .x(x), .y(y), .step_en(step_en),
        .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_val(wr_val),
        .r(r), .g(g), .b(b), .busy(busy), .generation(generation)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input int rr, input int cc, input bit v);
        wr_en  = 1'b1;
        wr_row = 6'(rr);
        wr_col = 7'(cc);
        wr_val = v;
        tick();
        wr_en = 1'b0;
        if (rr < GH && cc < GW) m[rr][cc] = v;
    endtask

    task automatic read_cell(input int rr, input int cc,
                             output logic [7:0] v);
        step_en = 1'b0;
        x = 10'(cc * 8 + 3);
        y = 10'(rr * 8 + 3);
        tick();
        v = r;
    endtask

    task automatic cmp_grid(input string tag);
        int bad;
        logic [7:0] e;
        bad = 0;
        step_en = 1'b0;
        for (int rr = 0; rr < GH; rr++) begin
            for (int cc = 0; cc < GW; cc++) begin
                x = 10'(cc * 8 + int'($urandom_range(1, 7)));
                y = 10'(rr * 8 + int'($urandom_range(1, 7)));
                tick();
                e = m[rr][cc] ? 8'hFF : 8'h00;
                if (r !== e || g !== e || b !== e) bad++;
            end
        end
        chk(tag, bad, 0);
    endtask

    task automatic clear_grid();
        for (int rr = 0; rr < GH; rr++)
            for (int cc = 0; cc < GW; cc++)
                if (m[rr][cc]) poke(rr, cc, 1'b0);
    endtask

    task automatic model_seed();
        logic [15:0] s;
        logic fb;
        s = 16'hACE1;
        for (int rr = 0; rr < GH; rr++) begin
            for (int cc = 0; cc < GW; cc++) begin
                m[rr][cc] = s[0];
                seed_m[rr][cc] = s[0];
                fb = s[16-16] ^ s[16-14] ^ s[16-13] ^ s[16-11];
                s = {fb, s[15:1]};
            end
        end
    endtask

    task automatic model_step();
        bit t [GH][GW];
        int n;
        for (int rr = 0; rr < GH; rr++) begin
            for (int cc = 0; cc < GW; cc++) begin
                n = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if (dr != 0 || dc != 0)
                            n += int'(m[(rr + dr + GH) % GH][(cc + dc + GW) % GW]);
                t[rr][cc] = (n == 3) || (m[rr][cc] && n == 2);
            end
        end
        m = t;
        exp_gen = (exp_gen + 1) & 16'hFFFF;
    endtask

    // Trigger one generation; pokes in the trigger cycle and while busy
    // must be dropped, so the model never applies them.
    task automatic do_step(input bit poke_in_trig);
        int len;
        x = 10'd0;
        y = 10'd480;
        step_en = 1'b1;
        if (poke_in_trig) begin
            wr_en  = 1'b1;
            wr_row = 6'd30;
            wr_col = 7'd30;
            wr_val = 1'b1;
        end
        tick();
        wr_en = 1'b0;
        step_en = 1'b0;
        x = 10'd1;
        y = 10'd0;
        chk("busy_rise", busy, 1);
        len = 0;
        while (busy === 1'b1 && len < 6000) begin
            len++;
            if (len == 3) begin
                wr_en  = 1'b1;
                wr_row = 6'($urandom_range(0, GH - 1));
                wr_col = 7'($urandom_range(0, GW - 1));
                wr_val = 1'($urandom);
            end
            tick();
            wr_en = 1'b0;
        end
        chk("step_len", len, STEP_LEN);
        model_step();
        chk("generation", generation, exp_gen);
    endtask

    task automatic wait_seed(input string tag);
        int len;
        bit lit;
        len = 1;
        lit = 1'b0;
        x = 10'd8;
        y = 10'd8;
        while (busy === 1'b1 && len < 6000) begin
            tick();
            if (busy === 1'b1) begin
                len++;
                if (r !== 8'h00) lit = 1'b1;
            end
        end
        chk({tag, "_len"}, len, GW * GH);
        chk({tag, "_dark"}, lit, 0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v;
        logic [7:0] e;
        rst = 1'b1;
        x = '0;
        y = '0;
        step_en = 1'b0;
        wr_en = 1'b0;
        wr_row = '0;
        wr_col = '0;
        wr_val = 1'b0;
        tick();
        tick();
        chk("rst_busy", busy, 1);
        chk("rst_gen", generation, 0);
        chk("rst_rgb", {r, g, b}, 0);
        rst = 1'b0;
        wait_seed("seed");
        model_seed();
        chk("seed_gen", generation, 0);
        cmp_grid("seed_grid");

        // random soup, including out-of-range pokes
        repeat (400)
            poke(int'($urandom_range(0, 63)), int'($urandom_range(0, 127)),
                 1'($urandom));
        cmp_grid("poke_grid");
        do_step(1'b0);
        cmp_grid("soup_grid");

        clear_grid();
        poke(10, 10, 1'b1);
        poke(10, 11, 1'b1);
        poke(10, 12, 1'b1);
        do_step(1'b0);
        read_cell(9, 11, v);
        chk("blinker_9_11", v, 8'hFF);
        read_cell(10, 11, v);
        chk("blinker_10_11", v, 8'hFF);
        read_cell(11, 11, v);
        chk("blinker_11_11", v, 8'hFF);
        read_cell(10, 10, v);
        chk("blinker_10_10", v, 8'h00);
        read_cell(10, 12, v);
        chk("blinker_10_12", v, 8'h00);

        poke(5, 5, 1'b1);
        poke(5, 6, 1'b1);
        poke(6, 5, 1'b1);
        poke(6, 6, 1'b1);
        repeat (3) do_step(1'b0);
        read_cell(5, 5, v);
        chk("block_5_5", v, 8'hFF);
        read_cell(6, 6, v);
        chk("block_6_6", v, 8'hFF);
        read_cell(4, 5, v);
        chk("block_4_5", v, 8'h00);

        // glider at the corner; (30,30) would complete a blinker if poked
        clear_grid();
        poke(57, 78, 1'b1);
        poke(58, 79, 1'b1);
        poke(59, 77, 1'b1);
        poke(59, 78, 1'b1);
        poke(59, 79, 1'b1);
        poke(30, 29, 1'b1);
        poke(30, 31, 1'b1);
        do_step(1'b1);
        repeat (3) do_step(1'b0);
        cmp_grid("glider_grid");
        read_cell(58, 79, v);
        chk("glider_58_79", v, 8'hFF);
        read_cell(59, 0, v);
        chk("glider_59_0", v, 8'hFF);
        read_cell(0, 78, v);
        chk("glider_0_78", v, 8'hFF);
        read_cell(0, 79, v);
        chk("glider_0_79", v, 8'hFF);
        read_cell(0, 0, v);
        chk("glider_0_0", v, 8'hFF);
        read_cell(57, 78, v);
        chk("glider_57_78", v, 8'h00);
        read_cell(59, 77, v);
        chk("glider_59_77", v, 8'h00);
        read_cell(30, 30, v);
        chk("trig_poke_drop", v, 8'h00);

        // pixel mapping and latency
        poke(2, 1, 1'b1);
        repeat (6) begin
            x = 10'(8 + int'($urandom_range(0, 7)));
            y = 10'(16 + int'($urandom_range(0, 7)));
            tick();
            chk("px_alive", {r, g, b}, 24'hFFFFFF);
        end
        x = 10'd8;
        y = 10'd16;
        tick();
        x = 10'd201;
        y = 10'd201;
        #2;
        chk("px_latency", r, 8'hFF);
        tick();
        chk("px_dead", {r, g, b}, 24'h000000);
        x = 10'd640;
        y = 10'd16;
        tick();
        chk("px_x640", {r, g, b}, 24'h000000);
        x = 10'd8;
        y = 10'd480;
        tick();
        chk("px_y480", {r, g, b}, 24'h000000);
        x = 10'd24;
        y = 10'd24;
        tick();
`ifdef GOL_GRID_LINES_EN
        e = m[3][3] ? 8'hFF : 8'h20;
`else
        e = m[3][3] ? 8'hFF : 8'h00;
`endif
        chk("px_gridline", r, e);

        // no step without step_en
        x = 10'd0;
        y = 10'd480;
        step_en = 1'b0;
        repeat (5) tick();
        chk("noen_busy", busy, 0);
        chk("noen_gen", generation, exp_gen);

        // reset in the middle of CELL
        step_en = 1'b1;
        tick();
        x = 10'd1;
        tick();
        repeat (100) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        step_en = 1'b0;
        chk("mid_rst_busy", busy, 1);
        chk("mid_rst_gen", generation, 0);
        wait_seed("reseed");
        exp_gen = 0;
        chk("reseed_gen", generation, 0);
        for (int i = 0; i < 16; i++) begin
            read_cell(0, i, v);
            chk("reseed_cell", v, seed_m[0][i] ? 8'hFF : 8'h00);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
